// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx -- serial pattern transmitter.
//
// Sends pattern[length:0] MSB-first, repeated (repeat_count + 1) times,
// as one contiguous burst on X / X_valid. A one-cycle done pulse follows
// the final bit. abort cancels a burst with no last and no done.
//
// The repetition port is named repeat_count because "repeat" is a
// reserved word in SystemVerilog.
//
// Optional feature macro: GEN_PARITY_EN
//   When defined, every pass is followed by one PARITY cycle carrying the
//   XOR of pattern_reg[length_reg:0]. last then marks the final parity bit.
//   When undefined, the PARITY state does not exist and passes run
//   back-to-back.
//
// Handshake: a request is accepted on a rising clock edge where
//   start_valid = 1, start_ready = 1 and abort = 0. start_ready is high
//   only in IDLE and does not depend on start_valid. The captured fields
//   are held for the whole burst, so the requester may change them freely
//   once the edge has passed.
//
// All outputs decode registered state only. No combinational path runs
// from any input to any output.
//
// state_dbg exposes the FSM state for external checkers:
//   0 = IDLE, 1 = SEND, 2 = PARITY (parity build only), 3 = DONE.

module seq_pattern_tx #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [7:0] pattern,
    input  logic [2:0] length,
    input  logic [3:0] repeat_count,
    input  logic       abort,
    output logic       X,
    output logic       X_valid,
    output logic       last,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
`ifdef GEN_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0] state,       state_nx;
    logic [7:0] pattern_reg, pattern_nx;
    logic [2:0] length_reg,  length_nx;
    logic [2:0] bit_idx,     bit_idx_nx;
    logic [3:0] rep_cnt,     rep_cnt_nx;
    logic       accept;

    // A request is taken only in IDLE, and abort blocks it.
    assign accept = start_valid && start_ready && !abort;

`ifdef GEN_PARITY_EN
    logic parity_bit;

    // Parity bit of the captured pattern, covering only bits length_reg..0.
    always_comb begin
        parity_bit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= length_reg) begin
                parity_bit = parity_bit ^ pattern_reg[i];
            end
        end
    end
`endif

    // Next-state logic: captures the request, steps through the bits and
    // reloads for each pass.
    always_comb begin
        state_nx   = state;
        pattern_nx = pattern_reg;
        length_nx  = length_reg;
        bit_idx_nx = bit_idx;
        rep_cnt_nx = rep_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    pattern_nx = pattern;
                    length_nx  = length;
                    bit_idx_nx = length;
                    rep_cnt_nx = repeat_count;
                    state_nx   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (bit_idx != 3'd0) begin
                    bit_idx_nx = bit_idx - 3'd1;
                end else begin
`ifdef GEN_PARITY_EN
                    // The end of each pass always goes through one parity cycle.
                    state_nx = ST_PARITY;
`else
                    if (rep_cnt != 4'd0) begin
                        // Reload in the same cycle so the passes run with no gap.
                        bit_idx_nx = length_reg;
                        rep_cnt_nx = rep_cnt - 4'd1;
                    end else begin
                        state_nx = ST_DONE;
                    end
`endif
                end
            end
`ifdef GEN_PARITY_EN
            ST_PARITY: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (rep_cnt != 4'd0) begin
                    bit_idx_nx = length_reg;
                    rep_cnt_nx = rep_cnt - 4'd1;
                    state_nx   = ST_SEND;
                end else begin
                    state_nx = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers, with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pattern_reg <= 8'd0;
            length_reg  <= 3'd0;
            bit_idx     <= 3'd0;
            rep_cnt     <= 4'd0;
        end else begin
            state       <= state_nx;
            pattern_reg <= pattern_nx;
            length_reg  <= length_nx;
            bit_idx     <= bit_idx_nx;
            rep_cnt     <= rep_cnt_nx;
        end
    end

    // Output decode from the registered state and counters only.
    always_comb begin
        start_ready = 1'b0;
        X           = IDLE_LEVEL;
        X_valid     = 1'b0;
        last        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
            end
            ST_SEND: begin
                X       = pattern_reg[bit_idx];
                X_valid = 1'b1;
`ifdef GEN_PARITY_EN
                last    = 1'b0;
`else
                last    = (bit_idx == 3'd0) && (rep_cnt == 4'd0);
`endif
            end
`ifdef GEN_PARITY_EN
            ST_PARITY: begin
                X       = parity_bit;
                X_valid = 1'b1;
                last    = (rep_cnt == 4'd0);
            end
`endif
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                start_ready = 1'b0;
            end
        endcase
    end

    // Expose the FSM state for external checkers.
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx -- directed scoreboard bench for seq_pattern_tx.
// The driver pushes hand-computed beats {X_valid, done, last, X} into exp_q.
// The monitor pops one entry and compares it on every cycle where the DUT
// shows a beat or a done pulse.
// Build with +define+GEN_PARITY_EN to exercise the parity variant.

module tb_seq_pattern_tx;

    localparam logic IDLE_LEVEL = 1'b1;

    logic       clock;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] pattern;
    logic [2:0] length;
    logic [3:0] repeat_count;
    logic       abort;
    logic       X;
    logic       X_valid;
    logic       last;
    logic       done;
    logic [1:0] state_dbg;

    logic [3:0] exp_q[$];
    int         n_cmp;
    int         n_bad;

    seq_pattern_tx #(.IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .length      (length),
        .repeat_count(repeat_count),
        .abort       (abort),
        .X           (X),
        .X_valid     (X_valid),
        .last        (last),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            check("start_ready", {31'd0, start_ready}, {31'd0, exp_q.size() == 0});
            if (X_valid || done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got v=%0b d=%0b l=%0b x=%0b expected none at %0t",
                             X_valid, done, last, X, $time);
                end else begin
                    check("beat", {28'd0, X_valid, done, last, X}, {28'd0, exp_q.pop_front()});
                end
            end else begin
                if (exp_q.size() != 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL gap: got idle cycle expected beat %0h at %0t", exp_q[0], $time);
                end
                check("idle_x", {31'd0, X}, {31'd0, IDLE_LEVEL});
                check("idle_last", {31'd0, last}, 32'd0);
            end
        end
    end

    // waits for the scoreboard to drain, with a cycle budget
    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    // handshake, then scramble the inputs and queue the hand-computed beats
    task automatic start_req(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r,
                             input logic [31:0] bits, input int n);
        @(posedge clock);
        #1;
        start_valid  = 1'b1;
        pattern      = p;
        length       = l;
        repeat_count = r;
        @(posedge clock);
        #1;
        start_valid  = 1'b0;
        pattern      = ~p;
        length       = ~l;
        repeat_count = ~r;
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back({1'b1, 1'b0, (i == 0), bits[i]});
        end
    endtask

    task automatic run_vec(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r,
                           input logic [31:0] bits, input int n);
        start_req(p, l, r, bits, n);
        exp_q.push_back({1'b0, 1'b1, 1'b0, IDLE_LEVEL});
        wait_drain();
    endtask

    // driver
    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        start_valid  = 1'b0;
        pattern      = 8'd0;
        length       = 3'd0;
        repeat_count = 4'd0;
        abort        = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_x",           {31'd0, X},           {31'd0, IDLE_LEVEL});
        check("rst_x_valid",     {31'd0, X_valid},     32'd0);
        check("rst_last",        {31'd0, last},        32'd0);
        check("rst_done",        {31'd0, done},        32'd0);
        check("rst_start_ready", {31'd0, start_ready}, 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;

`ifdef GEN_PARITY_EN
        run_vec(8'h06, 3'd3, 4'd0,  32'h0000000C, 5);
        run_vec(8'h06, 3'd3, 4'd2,  32'h0000318C, 15);
        run_vec(8'h01, 3'd0, 4'd15, 32'hFFFFFFFF, 32);
        run_vec(8'hA5, 3'd7, 4'd0,  32'h0000014A, 9);
        run_vec(8'hB2, 3'd5, 4'd1,  32'h000032E5, 14);
        run_vec(8'hFE, 3'd0, 4'd0,  32'h00000000, 2);
        run_vec(8'h06, 3'd3, 4'd1,  32'h0000018C, 10);
`else
        run_vec(8'h06, 3'd3, 4'd0,  32'h00000006, 4);
        run_vec(8'h06, 3'd3, 4'd2,  32'h00000666, 12);
        run_vec(8'h01, 3'd0, 4'd15, 32'h0000FFFF, 16);
        run_vec(8'hA5, 3'd7, 4'd0,  32'h000000A5, 8);
        run_vec(8'hB2, 3'd5, 4'd1,  32'h00000CB2, 12);
        run_vec(8'hFE, 3'd0, 4'd0,  32'h00000000, 1);
`endif

        // abort during the 2nd bit: only bits 0 and 1 appear, with no last and no done
        @(posedge clock);
        #1;
        start_valid  = 1'b1;
        pattern      = 8'h06;
        length       = 3'd3;
        repeat_count = 4'd0;
        @(posedge clock);
        #1;
        start_valid  = 1'b0;
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b1001);
        @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        @(negedge clock);
        check("abort_x_valid",     {31'd0, X_valid},     32'd0);
        check("abort_start_ready", {31'd0, start_ready}, 32'd1);
        check("abort_last",        {31'd0, last},        32'd0);
        check("abort_done",        {31'd0, done},        32'd0);
        repeat (4) @(negedge clock);

        // abort beats start_valid in IDLE: nothing is captured
        @(posedge clock);
        #1;
        start_valid = 1'b1;
        abort       = 1'b1;
        pattern     = 8'hFF;
        length      = 3'd7;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        abort       = 1'b0;
        @(negedge clock);
        check("abort_prio_ready",   {31'd0, start_ready}, 32'd1);
        check("abort_prio_x_valid", {31'd0, X_valid},     32'd0);
        repeat (3) @(negedge clock);

        // reset in the middle of SEND: outputs return to reset values at once
        start_req(8'hA5, 3'd7, 4'd0, 32'h000000A5, 8);
        @(negedge clock);
        @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_x",           {31'd0, X},           {31'd0, IDLE_LEVEL});
        check("midrst_x_valid",     {31'd0, X_valid},     32'd0);
        check("midrst_last",        {31'd0, last},        32'd0);
        check("midrst_done",        {31'd0, done},        32'd0);
        check("midrst_start_ready", {31'd0, start_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(negedge clock);
`ifdef GEN_PARITY_EN
        run_vec(8'h06, 3'd3, 4'd0, 32'h0000000C, 5);
`else
        run_vec(8'h06, 3'd3, 4'd0, 32'h00000006, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
